// File: rtl/clock_pkg.sv
// Shared constants, payload types and BCD helpers for the clock digit feeder.
package clock_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned SEG_W   = 8;
    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned WORD_W  = ADDR_W + SEG_W;
    localparam int unsigned IDX_W   = 4;

    // Segment patterns, bit7 DP .. bit0 G
    localparam logic [SEG_W-1:0] SEG_0     = 8'h7E;
    localparam logic [SEG_W-1:0] SEG_1     = 8'h30;
    localparam logic [SEG_W-1:0] SEG_2     = 8'h6D;
    localparam logic [SEG_W-1:0] SEG_3     = 8'h79;
    localparam logic [SEG_W-1:0] SEG_4     = 8'h33;
    localparam logic [SEG_W-1:0] SEG_5     = 8'h5B;
    localparam logic [SEG_W-1:0] SEG_6     = 8'h5F;
    localparam logic [SEG_W-1:0] SEG_7     = 8'h70;
    localparam logic [SEG_W-1:0] SEG_8     = 8'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 8'h7B;
    localparam logic [SEG_W-1:0] SEG_DASH  = 8'h01;
    localparam logic [SEG_W-1:0] SEG_BLANK = 8'h00;

    // MAX7219 digit register addresses, in frame order
    localparam logic [ADDR_W-1:0] ADDR_SEC_U   = 8'h01;
    localparam logic [ADDR_W-1:0] ADDR_SEC_T   = 8'h02;
    localparam logic [ADDR_W-1:0] ADDR_DASH_LO = 8'h03;
    localparam logic [ADDR_W-1:0] ADDR_MIN_U   = 8'h04;
    localparam logic [ADDR_W-1:0] ADDR_MIN_T   = 8'h05;
    localparam logic [ADDR_W-1:0] ADDR_DASH_HI = 8'h06;
    localparam logic [ADDR_W-1:0] ADDR_HOUR_U  = 8'h07;
    localparam logic [ADDR_W-1:0] ADDR_HOUR_T  = 8'h08;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [SEG_W-1:0]  seg;
    } cmd_word_t;

    typedef struct packed {
        logic [DIGIT_W-1:0] hour_t;
        logic [DIGIT_W-1:0] hour_u;
        logic [DIGIT_W-1:0] min_t;
        logic [DIGIT_W-1:0] min_u;
        logic [DIGIT_W-1:0] sec_t;
        logic [DIGIT_W-1:0] sec_u;
    } bcd_time_t;

    // Returns {wrap, next} for a two-digit BCD value counting 00..59.
    function automatic logic [8:0] bcd_inc60(input logic [7:0] v);
        if (v[3:0] != 4'd9) begin
            return {1'b0, v[7:4], v[3:0] + 4'd1};
        end
        if (v[7:4] != 4'd5) begin
            return {1'b0, v[7:4] + 4'd1, 4'd0};
        end
        return 9'h100;
    endfunction

    // Next value of a two-digit BCD hour counting 00..23.
    function automatic logic [7:0] bcd_inc24(input logic [7:0] v);
        if (v == 8'h23) begin
            return 8'h00;
        end
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// BCD digit to MAX7219 no-decode segment pattern; non-decimal codes render blank.
module seg7_encode
    import clock_pkg::*;
(
    input  logic [DIGIT_W-1:0] bcd,
    output logic [SEG_W-1:0]   seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        case (bcd)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            default: seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/clock_digit_feeder.sv
// 24h BCD clock that streams each time change to a MAX7219 SPI stage as an
// 8-word frame of {digit address, segment pattern}.
module clock_digit_feeder
    import clock_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 27000000,
    parameter int unsigned TICK_DIV = CLK_HZ
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_done,
    input  logic              set_min,
    input  logic              set_hour,
    output logic [WORD_W-1:0] cmd_data,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              sec_led
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0]  pre_q;
    bcd_time_t         time_q, time_d;
    logic              pending_q;
    logic              sec_led_q;
    logic              tick_c, change_c, load_c;
    logic [8:0]        sec_inc_c, min_inc_c;
    logic [7:0]        hour_inc_c, hour_adv_c;

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    bcd_time_t         snap_q, snap_d;
    cmd_word_t         word_q, word_d;
    logic              valid_q, valid_d;

    bcd_time_t         src_c;
    logic [IDX_W-1:0]  enc_idx_c;
    logic [DIGIT_W-1:0] digit_c;
    logic              dash_c;
    logic [SEG_W-1:0]  enc_seg_c;
    cmd_word_t         next_word_c;

    assign tick_c     = (pre_q == PRE_LAST);
    assign change_c   = tick_c | set_min | set_hour;
    assign sec_inc_c  = bcd_inc60({time_q.sec_t, time_q.sec_u});
    assign min_inc_c  = bcd_inc60({time_q.min_t, time_q.min_u});
    assign hour_inc_c = bcd_inc24({time_q.hour_t, time_q.hour_u});

    // Time update: set_min swallows a coincident tick, set_hour stacks on it.
    always_comb begin
        time_d     = time_q;
        hour_adv_c = {time_q.hour_t, time_q.hour_u};
        if (set_min) begin
            {time_d.min_t, time_d.min_u} = min_inc_c[7:0];
            {time_d.sec_t, time_d.sec_u} = 8'h00;
        end else if (tick_c) begin
            {time_d.sec_t, time_d.sec_u} = sec_inc_c[7:0];
            if (sec_inc_c[8]) begin
                {time_d.min_t, time_d.min_u} = min_inc_c[7:0];
                if (min_inc_c[8]) begin
                    hour_adv_c = hour_inc_c;
                end
            end
        end
        if (set_hour) begin
            hour_adv_c = bcd_inc24(hour_adv_c);
        end
        {time_d.hour_t, time_d.hour_u} = hour_adv_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            time_q    <= '0;
            pre_q     <= '0;
            pending_q <= 1'b1;
            sec_led_q <= 1'b0;
        end else begin
            time_q <= time_d;
            pre_q  <= (set_min || tick_c) ? '0 : pre_q + PRE_W'(1);
            if (tick_c && !set_min) begin
                sec_led_q <= ~sec_led_q;
            end
            // A change landing on the snapshot edge must survive the clear
            pending_q <= change_c ? 1'b1 : (load_c ? 1'b0 : pending_q);
        end
    end

    // LOAD encodes word 1 from live time; SEND encodes the next word from the snapshot
    assign src_c     = (state_q == ST_LOAD) ? time_q : snap_q;
    assign enc_idx_c = (state_q == ST_LOAD) ? IDX_W'(1) : idx_q + IDX_W'(1);

    always_comb begin
        digit_c = '0;
        dash_c  = 1'b0;
        case (ADDR_W'(enc_idx_c))
            ADDR_SEC_U:   digit_c = src_c.sec_u;
            ADDR_SEC_T:   digit_c = src_c.sec_t;
            ADDR_MIN_U:   digit_c = src_c.min_u;
            ADDR_MIN_T:   digit_c = src_c.min_t;
            ADDR_HOUR_U:  digit_c = src_c.hour_u;
            ADDR_HOUR_T:  digit_c = src_c.hour_t;
            ADDR_DASH_LO,
            ADDR_DASH_HI: dash_c  = 1'b1;
            default:      digit_c = '0;
        endcase
    end

    seg7_encode u_seg7_encode (
        .bcd   (digit_c),
        .seg_c (enc_seg_c)
    );

    assign next_word_c = {ADDR_W'(enc_idx_c), dash_c ? SEG_DASH : enc_seg_c};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            snap_q  <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    // Frame sequencer; init_done gates only the start of a frame
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        word_d  = word_q;
        valid_d = valid_q;
        load_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pending_q && init_done) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load_c  = 1'b1;
                snap_d  = time_q;
                idx_d   = IDX_W'(1);
                word_d  = next_word_c;
                valid_d = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (cmd_ready) begin
                    if (ADDR_W'(idx_q) == ADDR_HOUR_T) begin
                        valid_d = 1'b0;
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d  = idx_q + IDX_W'(1);
                        word_d = next_word_c;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cmd_data  = word_q;
    assign cmd_valid = valid_q;
    assign sec_led   = sec_led_q;

endmodule

// File: tb/tb_clock_digit_feeder.sv
// Directed bench for clock_digit_feeder with a seconds-of-day reference model.
module tb_clock_digit_feeder;

    localparam int TDIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_done = 1'b0;
    logic        set_min = 1'b0;
    logic        set_hour = 1'b0;
    logic        cmd_ready = 1'b1;
    logic [15:0] cmd_data;
    logic        cmd_valid;
    logic        sec_led;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  seg_tab [10] = '{8'h7E, 8'h30, 8'h6D, 8'h79, 8'h33,
                                  8'h5B, 8'h5F, 8'h70, 8'h7F, 8'h7B};
    logic [15:0] zero_frame [8] = '{16'h017E, 16'h027E, 16'h0301, 16'h047E,
                                    16'h057E, 16'h0601, 16'h077E, 16'h087E};

    // Reference model: time as seconds of day, frame as a word list
    bit          model_live = 1'b0;
    int          m_secs, m_pre, m_phase, m_k;
    bit          m_led, m_pending, m_valid;
    logic [15:0] m_data;
    logic [15:0] m_words [8];
    logic [15:0] acc [$];

    clock_digit_feeder #(
        .CLK_HZ   (TDIV),
        .TICK_DIV (TDIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .init_done (init_done),
        .set_min   (set_min),
        .set_hour  (set_hour),
        .cmd_data  (cmd_data),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .sec_led   (sec_led)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] frame_word(input int secs, input int w);
        int s = secs % 60;
        int m = (secs / 60) % 60;
        int h = secs / 3600;
        int d;
        case (w)
            0:       d = s % 10;
            1:       d = s / 10;
            3:       d = m % 10;
            4:       d = m / 10;
            6:       d = h % 10;
            7:       d = h / 10;
            default: d = -1;
        endcase
        return {8'(w + 1), (d < 0) ? 8'h01 : seg_tab[d]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        int  h;
        int  mn;
        bit  tick;
        bit  changed;
        bit  loading;
        if (rst) begin
            model_live = 1'b1;
            m_secs = 0; m_pre = 0; m_led = 1'b0; m_pending = 1'b1;
            m_phase = 0; m_k = 0; m_valid = 1'b0; m_data = 16'h0000;
        end else if (model_live) begin
            tick    = (m_pre == TDIV - 1);
            loading = (m_phase == 1);
            case (m_phase)
                0: if (m_pending && init_done) m_phase = 1;
                1: begin
                    for (int w = 0; w < 8; w++) m_words[w] = frame_word(m_secs, w);
                    m_k = 0; m_valid = 1'b1; m_data = m_words[0]; m_phase = 2;
                end
                default: if (cmd_ready) begin
                    m_k++;
                    if (m_k == 8) begin
                        m_phase = 0; m_valid = 1'b0;
                    end else begin
                        m_data = m_words[m_k];
                    end
                end
            endcase
            changed = set_min || set_hour || tick;
            if (set_min) begin
                m_pre = 0;
                h  = m_secs / 3600;
                mn = ((m_secs / 60) % 60 + 1) % 60;
                if (set_hour) h = (h + 1) % 24;
                m_secs = h * 3600 + mn * 60;
            end else begin
                m_pre = tick ? 0 : m_pre + 1;
                if (tick) begin
                    m_secs = (m_secs + 1) % 86400;
                    m_led  = !m_led;
                end
                if (set_hour) begin
                    h = (m_secs / 3600 + 1) % 24;
                    m_secs = h * 3600 + m_secs % 3600;
                end
            end
            if (changed) m_pending = 1'b1;
            else if (loading) m_pending = 1'b0;
        end
    end

    // Cycle-by-cycle comparison against the model, plus handshake log
    always @(negedge clk) begin
        if (model_live) begin
            chk("cmd_valid", 32'(cmd_valid), 32'(m_valid));
            chk("cmd_data", 32'(cmd_data), 32'(m_data));
            chk("sec_led", 32'(sec_led), 32'(m_led));
            if (cmd_valid && cmd_ready && !rst) acc.push_back(cmd_data);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold_reset(input bit init);
        rst = 1'b1; init_done = init; set_min = 1'b0; set_hour = 1'b0; cmd_ready = 1'b1;
        cyc(2);
        chk("rst_valid", 32'(cmd_valid), 32'd0);
        chk("rst_data", 32'(cmd_data), 32'h0000);
        chk("rst_led", 32'(sec_led), 32'd0);
        rst = 1'b0;
    endtask

    task automatic chk_acc(input string name, input int i, input logic [15:0] exp);
        if (i < acc.size()) chk(name, 32'(acc[i]), 32'(exp));
        else chk(name, 32'hFFFF_FFFF, 32'(exp));
    endtask

    initial begin
        // Boot frame: valid two cycles after release, eight back-to-back words
        hold_reset(1'b1);
        cyc(1);
        chk("boot_valid_c1", 32'(cmd_valid), 32'd0);
        cyc(1);
        chk("boot_valid_c2", 32'(cmd_valid), 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk("boot_word", 32'(cmd_data), 32'(zero_frame[i]));
            cyc(1);
        end
        chk("boot_end_valid", 32'(cmd_valid), 32'd0);

        // Back-pressure for 10 cycles mid-frame; init_done drops before the last word
        hold_reset(1'b1);
        acc.delete();
        cyc(5);
        cmd_ready = 1'b0;
        cyc(10);
        chk("stall_data", 32'(cmd_data), 32'h047E);
        chk("stall_valid", 32'(cmd_valid), 32'd1);
        cmd_ready = 1'b1;
        cyc(4);
        init_done = 1'b0;
        cyc(6);
        chk("stall_count", 32'(acc.size()), 32'd8);
        for (int i = 0; i < 8; i++) chk_acc("stall_word", i, zero_frame[i]);

        // Preload 23:59:59 and roll over to midnight
        hold_reset(1'b0);
        for (int i = 0; i < 59; i++) begin
            set_min = 1'b1;
            cyc(1);
        end
        set_min = 1'b0;
        set_hour = 1'b1;
        cyc(23);
        set_hour = 1'b0;
        cyc(216);
        chk("model_235959", 32'(m_secs), 32'd86399);
        cyc(1);
        chk("model_midnight", 32'(m_secs), 32'd0);
        init_done = 1'b1;
        acc.delete();
        cyc(12);
        chk("wrap_count", 32'(acc.size()), 32'd8);
        for (int i = 0; i < 8; i++) chk_acc("wrap_word", i, zero_frame[i]);

        // Tick lands inside a frame snapshotted at 00:00:05
        hold_reset(1'b0);
        cyc(22);
        chk("model_5s", 32'(m_secs), 32'd5);
        init_done = 1'b1;
        acc.delete();
        cyc(2);
        chk("mid_first_w1", 32'(cmd_data), 32'h015B);
        cyc(10);
        chk_acc("mid_frame_w1", 0, 16'h015B);
        chk_acc("mid_frame_w2", 1, 16'h027E);
        chk("mid_frame_count", 32'(acc.size()), 32'd8);
        chk("mid_next_w1", 32'(cmd_data), 32'h017F);

        // set_min coincident with a tick at 00:00:03
        hold_reset(1'b0);
        cyc(15);
        chk("model_3s", 32'(m_secs), 32'd3);
        set_min = 1'b1;
        cyc(1);
        set_min = 1'b0;
        chk("model_setmin", 32'(m_secs), 32'd60);
        chk("setmin_led", 32'(sec_led), 32'd1);
        init_done = 1'b1;
        acc.delete();
        cyc(12);
        chk_acc("setmin_w1", 0, 16'h017E);
        chk_acc("setmin_w4", 3, 16'h0430);
        chk_acc("setmin_w5", 4, 16'h057E);

        // Simultaneous set_min and set_hour
        hold_reset(1'b0);
        set_min = 1'b1;
        set_hour = 1'b1;
        cyc(1);
        set_min = 1'b0;
        set_hour = 1'b0;
        chk("model_both", 32'(m_secs), 32'd3660);
        init_done = 1'b1;
        acc.delete();
        cyc(12);
        chk_acc("both_w4", 3, 16'h0430);
        chk_acc("both_w7", 6, 16'h0730);
        chk_acc("both_w8", 7, 16'h087E);

        // Reset at word 4 aborts the frame; the next one restarts at address 1
        hold_reset(1'b1);
        cyc(5);
        chk("abort_pre_data", 32'(cmd_data), 32'h047E);
        rst = 1'b1;
        cyc(1);
        chk("abort_valid", 32'(cmd_valid), 32'd0);
        chk("abort_data", 32'(cmd_data), 32'h0000);
        rst = 1'b0;
        cyc(1);
        chk("restart_c1", 32'(cmd_valid), 32'd0);
        cyc(1);
        chk("restart_valid", 32'(cmd_valid), 32'd1);
        chk("restart_data", 32'(cmd_data), 32'h017E);

        cyc(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
